// File: rtl/solar_sweep_tracker.sv
// rtl/solar_sweep_tracker.sv - single-axis solar tracker sweep/seek/park controller
//
// Sweeps the panel through one revolution while recording the brightest
// sample and where it was seen, seeks back to that position, then parks with
// the motor off. A park can end on an explicit request or after a hold
// countdown when auto re-sweep is enabled.
//
// Ports:
//   CLOCK_50    in   system clock
//   reset       in   asynchronous active-low reset
//   sensor      in   light level (unsigned, already synchronous)
//   auto_rescan in   count down the hold period while parked and re-sweep
//   rescan_req  in   one-cycle pulse, starts a new sweep when parked
//   motor_on    out  motor enable (low only in PARK)
//   position    out  current step position
//   best_level  out  peak level of the current sweep
//   best_pos    out  position where best_level was captured
//   state       out  0=SCAN 1=SEEK 2=PARK
//   hold_left   out  remaining hold ticks while parked
//   sweep_done  out  one-cycle pulse when a sweep completes a revolution

module solar_sweep_tracker #(
  parameter int SENS_W      = 4,
  parameter int POS_W       = 4,
  parameter int SWEEP_STEPS = 11,
  parameter int TICK_DIV    = 50000000,
  parameter int HOLD_TICKS  = 10,
  parameter int MIN_LEVEL   = 1,
  parameter int HYST        = 0
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [SENS_W-1:0] sensor,
  input  logic              auto_rescan,
  input  logic              rescan_req,
  output logic              motor_on,
  output logic [POS_W-1:0]  position,
  output logic [SENS_W-1:0] best_level,
  output logic [POS_W-1:0]  best_pos,
  output logic [1:0]        state,
  output logic [3:0]        hold_left,
  output logic              sweep_done
);

  localparam int TICK_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_RELOAD = TICK_W'(TICK_DIV - 1);
  localparam logic [POS_W-1:0]  LAST_POS    = POS_W'(SWEEP_STEPS - 1);
  localparam logic [SENS_W-1:0] LEVEL_INIT  = SENS_W'(MIN_LEVEL);
  localparam logic [3:0]        HOLD_INIT   = 4'(HOLD_TICKS);
  localparam logic [SENS_W:0]   HYST_W      = (SENS_W + 1)'(HYST);

  typedef enum logic [1:0] {
    ST_SCAN   = 2'd0,
    ST_SEEK   = 2'd1,
    ST_PARK   = 2'd2,
    ST_UNUSED = 2'd3
  } state_t;

  state_t             r_state;
  logic               r_motor_on;
  logic [POS_W-1:0]   r_position;
  logic [SENS_W-1:0]  r_best_level;
  logic [POS_W-1:0]   r_best_pos;
  logic [3:0]         r_hold_left;
  logic               r_sweep_done;
  logic [TICK_W-1:0]  r_tick_cnt;
  logic [POS_W-1:0]   r_step_cnt;
  logic [SENS_W-1:0]  r_sensor_q;

  state_t             w_state_nxt;
  logic [POS_W-1:0]   w_position_nxt;
  logic [SENS_W-1:0]  w_best_level_nxt;
  logic [POS_W-1:0]   w_best_pos_nxt;
  logic [3:0]         w_hold_left_nxt;
  logic               w_sweep_done_nxt;
  logic [TICK_W-1:0]  w_tick_cnt_nxt;
  logic [POS_W-1:0]   w_step_cnt_nxt;
  logic               w_new_sweep;

  logic               w_tick;
  logic [POS_W-1:0]   w_pos_inc;
  logic               w_gain_scan;
  logic               w_gain_seek;

  assign w_tick      = (r_tick_cnt == '0);
  assign w_pos_inc   = (r_position == LAST_POS) ? '0 : r_position + POS_W'(1);
  assign w_gain_scan = (r_sensor_q > r_best_level);
  // One bit wider so best_level + HYST cannot wrap and fake an improvement.
  assign w_gain_seek = ({1'b0, r_sensor_q} > ({1'b0, r_best_level} + HYST_W));

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_SCAN;
      r_motor_on   <= 1'b1;
      r_position   <= '0;
      r_best_level <= LEVEL_INIT;
      r_best_pos   <= '0;
      r_hold_left  <= HOLD_INIT;
      r_sweep_done <= 1'b0;
      r_tick_cnt   <= TICK_RELOAD;
      r_step_cnt   <= '0;
      r_sensor_q   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_motor_on   <= (w_state_nxt != ST_PARK);
      r_position   <= w_position_nxt;
      r_best_level <= w_best_level_nxt;
      r_best_pos   <= w_best_pos_nxt;
      r_hold_left  <= w_hold_left_nxt;
      r_sweep_done <= w_sweep_done_nxt;
      r_tick_cnt   <= w_tick_cnt_nxt;
      r_step_cnt   <= w_step_cnt_nxt;
      r_sensor_q   <= sensor;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_position_nxt   = r_position;
    w_best_level_nxt = r_best_level;
    w_best_pos_nxt   = r_best_pos;
    w_hold_left_nxt  = r_hold_left;
    w_sweep_done_nxt = 1'b0;
    w_step_cnt_nxt   = r_step_cnt;
    w_new_sweep      = 1'b0;
    // Free-running divider by default; PARK without auto re-sweep pins it.
    w_tick_cnt_nxt   = w_tick ? TICK_RELOAD : r_tick_cnt - TICK_W'(1);

    case (r_state)
      ST_SEEK: begin
        if (w_tick) begin
          w_position_nxt = w_pos_inc;
        end
        // Arrival wins over an improvement seen on the way back.
        if (r_position == r_best_pos) begin
          w_state_nxt     = ST_PARK;
          w_hold_left_nxt = HOLD_INIT;
        end else if (w_gain_seek) begin
          w_state_nxt      = ST_SCAN;
          w_best_level_nxt = r_sensor_q;
          w_best_pos_nxt   = r_position;
          w_step_cnt_nxt   = '0;
        end
      end

      ST_PARK: begin
        if (rescan_req) begin
          w_new_sweep = 1'b1;
        end else if (auto_rescan) begin
          if (w_tick) begin
            if (r_hold_left == '0) begin
              w_new_sweep = 1'b1;
            end else begin
              w_hold_left_nxt = r_hold_left - 4'd1;
            end
          end
        end else begin
          w_hold_left_nxt = HOLD_INIT;
          w_tick_cnt_nxt  = TICK_RELOAD;
        end
      end

      default: begin
        // SCAN, and the unused encoding which behaves as SCAN.
        if (w_gain_scan) begin
          w_best_level_nxt = r_sensor_q;
          w_best_pos_nxt   = r_position;
        end
        if (w_tick) begin
          w_position_nxt = w_pos_inc;
          if (r_step_cnt == LAST_POS) begin
            w_state_nxt      = ST_SEEK;
            w_step_cnt_nxt   = '0;
            w_sweep_done_nxt = 1'b1;
          end else begin
            w_step_cnt_nxt = r_step_cnt + POS_W'(1);
          end
        end
      end
    endcase

    // A new sweep starts from wherever the panel is parked.
    if (w_new_sweep) begin
      w_state_nxt      = ST_SCAN;
      w_best_level_nxt = LEVEL_INIT;
      w_best_pos_nxt   = r_position;
      w_step_cnt_nxt   = '0;
      w_hold_left_nxt  = HOLD_INIT;
      w_tick_cnt_nxt   = TICK_RELOAD;
    end
  end

  assign motor_on   = r_motor_on;
  assign position   = r_position;
  assign best_level = r_best_level;
  assign best_pos   = r_best_pos;
  assign state      = r_state;
  assign hold_left  = r_hold_left;
  assign sweep_done = r_sweep_done;

endmodule

// File: tb/tb_solar_sweep_tracker.sv
// tb/tb_solar_sweep_tracker.sv - directed bench for solar_sweep_tracker

module tb_solar_sweep_tracker;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] sensor = 4'd0;
  logic       auto_rescan = 1'b0;
  logic       rescan_req = 1'b0;
  logic       motor_on;
  logic [3:0] position;
  logic [3:0] best_level;
  logic [3:0] best_pos;
  logic [1:0] state;
  logic [3:0] hold_left;
  logic       sweep_done;

  int n_cmp = 0;
  int n_err = 0;

  solar_sweep_tracker #(
    .SENS_W(4), .POS_W(4), .SWEEP_STEPS(4), .TICK_DIV(4),
    .HOLD_TICKS(2), .MIN_LEVEL(1), .HYST(0)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .sensor     (sensor),
    .auto_rescan(auto_rescan),
    .rescan_req (rescan_req),
    .motor_on   (motor_on),
    .position   (position),
    .best_level (best_level),
    .best_pos   (best_pos),
    .state      (state),
    .hold_left  (hold_left),
    .sweep_done (sweep_done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  function automatic logic [3:0] pattern(input int p);
    if (p == 1) return 4'd3;
    if (p == 2) return 4'd9;
    return 4'd5;
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, state, 0);
    check({tag, "_motor"}, motor_on, 1);
    check({tag, "_pos"}, position, 0);
    check({tag, "_best"}, best_level, 1);
    check({tag, "_bpos"}, best_pos, 0);
    check({tag, "_hold"}, hold_left, 2);
    check({tag, "_done"}, sweep_done, 0);
  endtask

  // Reset, then one full sweep from position 0 with sensor 3 at pos1,
  // 9 at pos2 and 5 elsewhere; returns one sample after the completing tick.
  task automatic first_sweep();
    reset = 1'b0;
    sensor = 4'd5;
    auto_rescan = 1'b0;
    rescan_req = 1'b0;
    cycles(1);
    check_reset_values("fs_rst");
    reset = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      cycles(1);
      if (e == 15) check("fs_still_scan", state, 0);
      sensor = pattern((e / 4) % 4);
    end
    check("fs_state_seek", state, 1);
    check("fs_done_pulse", sweep_done, 1);
    check("fs_best_level", best_level, 9);
    check("fs_best_pos", best_pos, 2);
    check("fs_pos_wrap", position, 0);
    check("fs_motor", motor_on, 1);
  endtask

  initial begin
    #2 reset = 1'b0;
    #1;
    check_reset_values("por");

    // Sweep, seek back to position 2 and park.
    first_sweep();
    cycles(1);
    check("done_one_cycle", sweep_done, 0);
    cycles(7);
    check("seek_pos2_state", state, 1);
    check("seek_pos2_pos", position, 2);
    cycles(1);
    check("park_state", state, 2);
    check("park_motor", motor_on, 0);
    check("park_pos", position, 2);
    check("park_hold", hold_left, 2);
    check("park_best_eq", best_level, 9);

    // Hold freeze with auto re-sweep off.
    cycles(100);
    check("freeze_state", state, 2);
    check("freeze_hold", hold_left, 2);
    check("freeze_pos", position, 2);
    check("freeze_motor", motor_on, 0);

    // Auto re-sweep countdown.
    sensor = 4'd0;
    auto_rescan = 1'b1;
    cycles(4);
    check("auto_hold1", hold_left, 1);
    cycles(4);
    check("auto_hold0", hold_left, 0);
    cycles(3);
    check("auto_still_park", state, 2);
    cycles(1);
    check("auto_scan", state, 0);
    check("auto_best_reload", best_level, 1);
    check("auto_bpos", best_pos, 2);
    check("auto_hold_reload", hold_left, 2);
    check("auto_motor", motor_on, 1);
    check("auto_pos_kept", position, 2);

    // That sweep runs a full revolution from 2 and parks right away.
    cycles(16);
    check("rs_seek", state, 1);
    check("rs_done", sweep_done, 1);
    check("rs_pos", position, 2);
    cycles(1);
    check("rs_park", state, 2);
    check("rs_park_hold", hold_left, 2);
    cycles(10);
    check("pri_hold0", hold_left, 0);
    check("pri_park", state, 2);

    // rescan_req coincides with the hold-expiry tick.
    rescan_req = 1'b1;
    cycles(1);
    rescan_req = 1'b0;
    check("pri_scan", state, 0);
    check("pri_hold", hold_left, 2);
    check("pri_best", best_level, 1);
    check("pri_motor", motor_on, 1);
    cycles(3);
    check("pri_pos_before_tick", position, 2);
    cycles(1);
    check("pri_pos_after_tick", position, 3);
    check("pri_still_scan", state, 0);

    // SEEK improvement at position 0.
    first_sweep();
    sensor = 4'd12;
    cycles(1);
    check("imp_seek_latency", state, 1);
    cycles(1);
    check("imp_scan", state, 0);
    check("imp_best", best_level, 12);
    check("imp_bpos", best_pos, 0);
    check("imp_pos", position, 0);
    cycles(14);
    check("imp_seek", state, 1);
    check("imp_done", sweep_done, 1);
    check("imp_best_eq", best_level, 12);
    check("imp_bpos_eq", best_pos, 0);
    check("imp_pos_wrap", position, 0);
    cycles(1);
    check("imp_park", state, 2);
    check("imp_park_motor", motor_on, 0);
    check("imp_park_pos", position, 0);

    // Asynchronous reset in the middle of SEEK.
    first_sweep();
    cycles(4);
    check("mid_seek_state", state, 1);
    check("mid_seek_pos", position, 1);
    #2 reset = 1'b0;
    #1;
    check_reset_values("async");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
